// File: rtl/uart_rx.sv
// uart_rx: UART receiver to valid/ready stream with rts flow control; optional parity bit via UART_RX_PARITY_EN
module uart_rx #(
  parameter int MAX_BITS     = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [MAX_BITS-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                rts,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(MAX_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          bits_q, bits_d;
  logic [MAX_BITS-1:0] shift_q, shift_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;
  logic                deliver;
  logic                line;
`ifdef UART_RX_PARITY_EN
  logic                par_q, par_d;
  logic                perr_q, perr_d;
`endif

  assign line = sync_q[1];

  // Frame FSM, bit-period counter, shifter and output register next-state
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], rx};
    cnt_d   = cnt_q + 1'b1;
    bits_d  = bits_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = line ? IDLE : START;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d   = '0;
        bits_d  = '0;
        state_d = line ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        par_d   = PARITY_ODD;
`endif
      end
      DATA: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        shift_d = {line, shift_q[MAX_BITS-1:1]};
        bits_d  = bits_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q ^ line;
        state_d = (bits_q == LAST_BIT) ? PARITY : DATA;
`else
        state_d = (bits_q == LAST_BIT) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        par_d   = par_q ^ line;
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        ferr_d  = !line;
        state_d = line ? IDLE : BRK;
`ifdef UART_RX_PARITY_EN
        perr_d  = line && par_q;
        deliver = line && !par_q;
`else
        deliver = line;
`endif
      end
      BRK: state_d = line ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
    if (deliver && (!valid_q || ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end
    ovr_d = deliver && valid_q && !ready;
  end

  // State and datapath registers; synchronizer resets to idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign rts       = !valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = PARITY_ODD & 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx (defaults: 8 data bits, 16 clocks per bit)
module tb_uart_rx;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif
  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b1;
  logic [7:0] data;
  logic       valid, rts, frame_err, parity_err, overrun;
  int         checks = 0, errors = 0, cyc = 0;
  int         n_valid, n_rts_low, n_ferr, n_perr, n_ovr, first_valid, ovr_cyc;
  logic [7:0] last_data;
  int         t;

  uart_rx dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .rts(rts), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge
  always @(negedge clk) if (!rst) begin
    if (valid) begin
      if (n_valid == 0) first_valid = cyc;
      n_valid++;
      last_data = data;
    end
    if (!rts) n_rts_low++;
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (overrun) begin
      ovr_cyc = cyc;
      n_ovr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_valid = 0; n_rts_low = 0; n_ferr = 0; n_perr = 0; n_ovr = 0;
    first_valid = -1; ovr_cyc = -1; last_data = 8'hxx;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic bad_par, input logic stop_b);
    logic [10:0] f;
    int n;
    f = {stop_b, ^d ^ bad_par, d, 1'b0};
    n = 11;
`ifndef UART_RX_PARITY_EN
    f[9] = stop_b;
    n = 10;
`endif
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  task automatic no_err(input string tag);
    chk({tag, " ferr"}, n_ferr, 0);
    chk({tag, " perr"}, n_perr, 0);
    chk({tag, " ovr"}, n_ovr, 0);
  endtask

  initial begin
    clr();
    idle(3);
    rst = 1'b0;
    idle(5);
    chk("rst data", data, 0);
    chk("rst valid", valid, 0);
    chk("rst rts", rts, 1);
    chk("rst ferr", frame_err, 0);
    chk("rst ovr", overrun, 0);
    chk("rst perr", parity_err, 0);

    clr();
    t = cyc;
    send(8'h55, 1'b0, 1'b1);
    idle(20);
    chk("t1 latency", first_valid - t, LAT);
    chk("t1 nvalid", n_valid, 1);
    chk("t1 data", last_data, 8'h55);
    chk("t1 rts low", n_rts_low, 1);
    no_err("t1");

    clr();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    chk("t2 glitch nvalid", n_valid, 0);
    no_err("t2 glitch");
    send(8'hC3, 1'b0, 1'b1);
    idle(20);
    chk("t2 nvalid", n_valid, 1);
    chk("t2 data", last_data, 8'hC3);

    clr();
    send(8'hA3, 1'b0, 1'b0);
    idle(40);
    rx = 1'b1;
    idle(20);
    chk("t3 ferr", n_ferr, 1);
    chk("t3 nvalid", n_valid, 0);
    chk("t3 perr", n_perr, 0);
    send(8'h0F, 1'b0, 1'b1);
    idle(20);
    chk("t3 next nvalid", n_valid, 1);
    chk("t3 next data", last_data, 8'h0F);
    chk("t3 next ferr", n_ferr, 1);

    clr();
    ready = 1'b0;
    send(8'h12, 1'b0, 1'b1);
    t = cyc;
    send(8'h34, 1'b0, 1'b1);
    idle(20);
    chk("t4 valid", valid, 1);
    chk("t4 data", data, 8'h12);
    chk("t4 rts", rts, 0);
    chk("t4 novr", n_ovr, 1);
    chk("t4 ovr time", ovr_cyc - t, LAT);
    chk("t4 ferr", n_ferr, 0);
    ready = 1'b1;
    @(negedge clk);
    chk("t4 hs valid", valid, 1);
    @(posedge clk);
    #1;
    chk("t4 drop valid", valid, 0);
    chk("t4 drop rts", rts, 1);
    chk("t4 keep data", data, 8'h12);

    clr();
    ready = 1'b0;
    send(8'h5A, 1'b0, 1'b1);
    idle(10);
    fork
      send(8'h7E, 1'b0, 1'b1);
      begin
        repeat (69) @(posedge clk);
        #2;
        chk("t5 pre valid", valid, 1);
        chk("t5 pre data", data, 8'h5A);
        #1;
        rst = 1'b1;
        #1;
        chk("t5 rst data", data, 0);
        chk("t5 rst valid", valid, 0);
        chk("t5 rst rts", rts, 1);
        chk("t5 rst ferr", frame_err, 0);
      end
    join
    idle(10);
    rst = 1'b0;
    ready = 1'b1;
    idle(10);
    clr();
    send(8'h81, 1'b0, 1'b1);
    idle(20);
    chk("t5 nvalid", n_valid, 1);
    chk("t5 data", last_data, 8'h81);
    no_err("t5");

`ifdef UART_RX_PARITY_EN
    clr();
    send(8'h07, 1'b0, 1'b1);
    idle(20);
    chk("t6 good nvalid", n_valid, 1);
    chk("t6 good data", last_data, 8'h07);
    chk("t6 good perr", n_perr, 0);
    clr();
    send(8'h07, 1'b1, 1'b1);
    idle(20);
    chk("t6 bad perr", n_perr, 1);
    chk("t6 bad nvalid", n_valid, 0);
    chk("t6 bad ferr", n_ferr, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable UART receiver: deserializes an asynchronous 8N1-style serial line into a `MAX_BITS`-wide valid/ready stream. It is the hardware end of the link whose host side the simulation UART models provide. It sits between the `rx` pad and on-chip consumers, and drives `rts` flow control back to the remote transmitter.

## Interface
- `MAX_BITS`, 8: data bits per frame, LSB first; range 5..9.
- `CLKS_PER_BIT`, 16: `clk` cycles per bit period; integer ≥ 4.
- `PARITY_ODD`, 0: parity sense when parity is compiled in (0 = even, 1 = odd); ignored otherwise.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rx`  in  1  serial input; idle high; asynchronous to `clk`.
- `data`  out  MAX_BITS  received word; stable while `valid`.
- `valid`  out  1  `data` holds an unconsumed word.
- `ready`  in  1  consumer accepts; transfer when `valid && ready`.
- `rts`  out  1  ready-to-send to the remote end; equals `!valid`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: frame completed while `valid && !ready`; that frame is dropped.

## Operation
- `rx` passes through a 2-FF synchronizer, reset to 1; "line" below means the synchronizer output.
- Bit-period counter: `H = CLKS_PER_BIT/2` (floor), `C = CLKS_PER_BIT`.
- States:
  - IDLE: line low → START, counter cleared.
  - START: after `H` cycles, sample line. Low → DATA. High → IDLE (glitch; no error reported).
  - DATA: every `C` cycles, sample one bit, shifting in LSB first. After `MAX_BITS` samples → PARITY if compiled in, else STOP.
  - PARITY: after `C` cycles, sample the parity bit and compare → STOP.
  - STOP: after `C` cycles, sample the stop bit.
    - High with no parity error → deliver, then IDLE.
    - Low → `frame_err` pulse, discard, → BREAK.
    - High with parity error → `parity_err` pulse, discard, → IDLE.
  - BREAK: wait for line high → IDLE. Prevents a held-low line from being read as repeated 0x00 frames.
- Deliver into the output register:
  - If `!valid` or `ready` in the same cycle: load `data`, `valid`=1.
  - Else: `overrun` pulse; `data`/`valid` unchanged.
- Handshake: `valid && ready` with no delivery in that cycle → `valid`=0 next cycle. `data` keeps its last value after consumption.
- Simultaneous handshake and delivery → new word loaded, `valid` stays 1, no overrun.
- Reset values: `data`=0, `valid`=0, `rts`=1, all error pulses 0, state IDLE.
- Reset mid-frame aborts the frame with no error pulse.

## Timing
- t0 = first cycle the line is low in IDLE; pin-to-line latency is 2 cycles.
- Start sample at t0+H.
- Data bit i (0-based) sampled at t0+H+(i+1)·C.
- Parity sampled at t0+H+(MAX_BITS+1)·C.
- Stop sampled at t0+H+(MAX_BITS+1+P)·C, where P=1 with parity and 0 without. Call this ts.
- `valid` rises, or the `frame_err`/`parity_err`/`overrun` pulse fires, at ts+1.
- From STOP, a new start edge is detected from the cycle after ts. Back-to-back frames with one stop bit are supported.
- `rts` changes in the same cycle as `valid`, combinationally.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - One parity bit follows the data bits, with sense set by `PARITY_ODD`.
  - On mismatch, `parity_err` pulses and the word is discarded.
- Not defined:
  - No parity bit; the frame is start + `MAX_BITS` + stop.
  - `parity_err` is tied 0 and the PARITY state is absent.

## Test plan
1. C=16, MAX_BITS=8, `ready`=1, send 0x55 → `valid` high for exactly one cycle at t0+153 with `data`=0x55; `rts` low that cycle only.
2. `rx` low for 4 cycles, then high → no `valid` and no error pulses; a following frame 0xC3 is received correctly.
3. Frame 0xA3 with the stop bit low, then `rx` held low 40 cycles, then high → one `frame_err` pulse, no `valid`; the next frame 0x0F is delivered.
4. `ready`=0, send 0x12 then 0x34 → `valid` held with `data`=0x12, `rts`=0, one `overrun` pulse at the second stop +1. Then `ready`=1 → `valid` falls the next cycle.
5. Assert `rst` during DATA bit 3 of 0x7E → all outputs at reset values immediately; the next frame 0x81 is received correctly.
6. With `UART_RX_PARITY_EN`, even parity: 0x07 with parity bit 1 → delivered. 0x07 with parity bit 0 → one `parity_err` pulse, no `valid`.
